// File: rtl/dma_step_counter_pkg.sv
// Shared types and encodings for the DMA step counter.
// Purely declarative; no latency or backpressure of its own.
package dma_cnt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_RUN   = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        MODE_ONESHOT = 2'b00,
        MODE_RELOAD  = 2'b01,
        MODE_FREERUN = 2'b10
    } mode_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // The unused 2'b11 encoding behaves as one-shot.
    function automatic mode_t norm_mode(input logic [1:0] m);
        case (m)
            2'b01:   return MODE_RELOAD;
            2'b10:   return MODE_FREERUN;
            default: return MODE_ONESHOT;
        endcase
    endfunction

endpackage

// File: rtl/dma_step_counter_if.sv
// Programming/control bundle between the DMA register file, transfer engine and step counter.
// master drives programming and strobes; slave is the counter returning status.
interface dma_step_counter_if #(
    parameter int W      = 16,
    parameter int STEP_W = 4
) ();
    logic              load;
    logic [W-1:0]      base_in;
    logic [W-1:0]      limit_in;
    logic [STEP_W-1:0] stride_in;
    logic              dir_in;
    logic [1:0]        mode_in;
    logic              start;
    logic              stop;
    logic              adv;
    logic [W-1:0]      cnt;
    logic              busy;
    logic              armed;
    logic              done;
    logic              tc;
    logic              load_err;

    modport master (
        output load, base_in, limit_in, stride_in, dir_in, mode_in, start, stop, adv,
        input  cnt, busy, armed, done, tc, load_err
    );

    modport slave (
        input  load, base_in, limit_in, stride_in, dir_in, mode_in, start, stop, adv,
        output cnt, busy, armed, done, tc, load_err
    );
endinterface

// File: rtl/dma_step_counter_step.sv
// Next-value and terminal-condition datapath for one stride step.
// Combinational, zero latency; no backpressure.
module dma_cnt_step
    import dma_cnt_pkg::*;
#(
    parameter int W      = 16,
    parameter int STEP_W = 4
) (
    input  logic [W-1:0]      cnt,
    input  logic [STEP_W-1:0] stride,
    input  logic              dir,
    input  mode_t             mode,
    input  logic [W-1:0]      limit,
    output logic [W-1:0]      nxt,
    output logic              term
);
    logic [STEP_W-1:0] stride_eff;
    logic [W:0]        step_ext;
    logic [W:0]        sum;
    logic [W:0]        diff;

    // A zero stride would stall the counter forever, so it steps by one instead.
    assign stride_eff = (stride == '0) ? {{(STEP_W-1){1'b0}}, 1'b1} : stride;
    assign step_ext   = {{(W+1-STEP_W){1'b0}}, stride_eff};
    assign sum        = {1'b0, cnt} + step_ext;
    assign diff       = {1'b0, cnt} - step_ext;

    always_comb begin
        nxt  = sum[W-1:0];
        term = 1'b0;
        if (dir == DIR_UP) begin
            nxt  = sum[W-1:0];
            term = (mode == MODE_FREERUN) ? sum[W] : (sum >= {1'b0, limit});
        end else begin
            nxt  = diff[W-1:0];
            term = (mode == MODE_FREERUN) ? diff[W] : (diff[W] || (diff[W-1:0] <= limit));
        end
    end
endmodule

// File: rtl/dma_step_counter.sv
// Programmable base/limit/stride address counter with one-shot, reload and free-run modes.
// One-cycle latency from adv to cnt; all outputs registered; adv accepted every cycle in RUN.
module dma_step_counter
    import dma_cnt_pkg::*;
#(
    parameter int W      = 16,
    parameter int STEP_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    dma_step_counter_if.slave  bus
);
    state_t            state;
    logic [W-1:0]      cnt_q;
    logic [W-1:0]      base_q;
    logic [W-1:0]      limit_q;
    logic [STEP_W-1:0] stride_q;
    logic              dir_q;
    mode_t             mode_q;
    logic              busy_q, armed_q, done_q, tc_q, load_err_q;
    logic [W-1:0]      step_nxt;
    logic              step_term;

    dma_cnt_step #(.W(W), .STEP_W(STEP_W)) u_step (
        .cnt    (cnt_q),
        .stride (stride_q),
        .dir    (dir_q),
        .mode   (mode_q),
        .limit  (limit_q),
        .nxt    (step_nxt),
        .term   (step_term)
    );

    // Priority: stop > load > start > adv; a rejected load in RUN still consumes the cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt_q      <= '0;
            base_q     <= '0;
            limit_q    <= '0;
            stride_q   <= '0;
            dir_q      <= DIR_UP;
            mode_q     <= MODE_ONESHOT;
            busy_q     <= 1'b0;
            armed_q    <= 1'b0;
            done_q     <= 1'b0;
            tc_q       <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            tc_q       <= 1'b0;
            load_err_q <= 1'b0;
            if (bus.stop && state != ST_IDLE) begin
                state   <= ST_IDLE;
                busy_q  <= 1'b0;
                armed_q <= 1'b0;
                done_q  <= 1'b0;
            end else if (bus.load) begin
                if (state == ST_RUN) begin
                    load_err_q <= 1'b1;
                end else begin
                    base_q   <= bus.base_in;
                    limit_q  <= bus.limit_in;
                    stride_q <= bus.stride_in;
                    dir_q    <= bus.dir_in;
                    mode_q   <= norm_mode(bus.mode_in);
                    cnt_q    <= bus.base_in;
                    state    <= ST_ARMED;
                    armed_q  <= 1'b1;
                    done_q   <= 1'b0;
                    busy_q   <= 1'b0;
                end
            end else if (bus.start && state == ST_ARMED) begin
                state   <= ST_RUN;
                armed_q <= 1'b0;
                busy_q  <= 1'b1;
            end else if (bus.adv && state == ST_RUN) begin
                if (step_term) begin
                    tc_q <= 1'b1;
                    case (mode_q)
                        MODE_RELOAD:  cnt_q <= base_q;
                        MODE_FREERUN: cnt_q <= step_nxt;
                        default: begin
                            cnt_q  <= limit_q;
                            state  <= ST_DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    endcase
                end else begin
                    cnt_q <= step_nxt;
                end
            end
        end
    end

    assign bus.cnt      = cnt_q;
    assign bus.busy     = busy_q;
    assign bus.armed    = armed_q;
    assign bus.done     = done_q;
    assign bus.tc       = tc_q;
    assign bus.load_err = load_err_q;
endmodule

// File: doc/dma_step_counter.md
# dma_step_counter

Parametrised successor to the DMA controller's basic up-counter. It generates transfer addresses or lengths from a programmed base, limit, stride and direction, and supports three modes: one-shot, auto-reload and free-run wrap. It runs an explicit load/arm/run lifecycle and emits a registered terminal-count pulse. It sits between the DMA register file, which programs it, and the transfer engine, which issues `adv` once per completed beat.

## Interface
Parameters:
- `W`, 16: counter, base and limit width.
- `STEP_W`, 4: stride width.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load`  in  1  latch programming inputs; accepted only in IDLE, ARMED or DONE.
- `base_in`  in  W  start value, also the reload value.
- `limit_in`  in  W  terminal bound; ignored in free-run.
- `stride_in`  in  STEP_W  step size; 0 is treated as 1.
- `dir_in`  in  1  0 = count up, 1 = count down.
- `mode_in`  in  2  00 one-shot, 01 auto-reload, 10 free-run; 11 is treated as 00.
- `start`  in  1  ARMED to RUN.
- `stop`  in  1  abort to IDLE; `cnt` holds its value.
- `adv`  in  1  advance one stride; effective in RUN only.
- `cnt`  out  W  current value.
- `busy`  out  1  high in RUN.
- `armed`  out  1  high in ARMED.
- `done`  out  1  high in DONE.
- `tc`  out  1  one-cycle terminal-count pulse.
- `load_err`  out  1  one-cycle pulse when `load` is asserted in RUN.

## Operation
- States are IDLE, ARMED, RUN and DONE.
- **Load.** In IDLE, ARMED or DONE, `load` latches base, limit, stride, dir and mode, sets `cnt <= base_in`, and moves to ARMED.
- **Start.** In ARMED, `start` moves to RUN.
- **Advance up.** Compute `sum = {1'b0,cnt} + stride` (W+1 bits).
  - One-shot or auto-reload: the terminal condition is `sum >= {1'b0,limit}`.
  - Free-run: the terminal condition is `sum[W]` (carry out).
- **Advance down.** Compute `diff = {1'b0,cnt} - stride`.
  - One-shot or auto-reload: the terminal condition is borrow (`diff[W]`) or `diff[W-1:0] <= limit`.
  - Free-run: the terminal condition is borrow only.
- **On terminal.** `tc` pulses in every mode, then:
  - One-shot: `cnt <= limit`, and the state moves to DONE.
  - Auto-reload: `cnt <= base`, and the state stays in RUN.
  - Free-run: `cnt <= sum[W-1:0]` or `diff[W-1:0]` (wraps modulo 2^W), and the state stays in RUN.
- **Non-terminal advance.** `cnt` takes the sum or difference.
- **Priority.** `stop` > `load` > `start` > `adv`.
  - `load` and `start` in the same cycle: the load is taken and the start ignored.
  - `stop` in IDLE has no effect.
- **Ignored inputs.**
  - `adv` outside RUN is ignored.
  - `load` in RUN is ignored and pulses `load_err`.
  - `start` outside ARMED is ignored.
- **Reset.** `rst_n` low, including mid-RUN, immediately forces:
  - state IDLE;
  - `cnt` and all latched programming registers to 0;
  - all outputs to 0.

## Timing
- All outputs are registered.
- `cnt` reflects an `adv` sampled at edge N immediately after edge N, so latency is 1 cycle.
- `tc` is high for exactly the one cycle that `cnt` shows the terminal result (limit, base or wrapped value).
- `done` rises in the same cycle as the final `tc` and holds until `load` or `stop`.
- With `adv` held high continuously in RUN, `cnt` updates every cycle with no bubbles.
- After `start`, the first `adv` is honoured on the cycle following the transition to RUN.

## Structure
- Package `dma_cnt_pkg` holds:
  - the state enum (IDLE, ARMED, RUN, DONE);
  - the mode encodings (`MODE_ONESHOT`, `MODE_RELOAD`, `MODE_FREERUN`);
  - the direction constants.
- Sub-module `dma_cnt_step` is purely combinational. It takes cnt, stride, dir, mode and limit, and returns the next value and a terminal flag.
- The top level holds the FSM and registers only.

## Test plan
- **Up one-shot with exact hit.** Program W=16, base 0x0010, limit 0x0020, stride 4, one-shot; `start`; hold `adv`.
  - Required: `cnt` goes 0x0010, 0x0014, 0x0018, 0x001C, 0x0020.
  - `tc` pulses with 0x0020, then `done`=1 and `busy`=0; further `adv` leaves 0x0020.
- **Overshoot saturation.** Base 0, limit 10, stride 4, up, one-shot.
  - Required: `cnt` goes 0, 4, 8, 10, with `tc` on 10.
- **Down auto-reload.** Base 0x0008, limit 0, stride 3; hold `adv`.
  - Required: `cnt` goes 8, 5, 2, 8 (`tc` here), 5, …; `busy` stays 1.
- **Free-run wrap and stride 0.** Base 0xFFFE, stride 0 (treated as 1), up, free-run, limit 0x0005.
  - Required: `cnt` goes 0xFFFE, 0xFFFF, 0x0000 (`tc` here), 0x0001; the limit is ignored.
- **Priority.** In RUN, assert `stop`+`adv` together.
  - Required: IDLE next cycle with `cnt` unchanged.
  - Separately, `load` in RUN leaves `cnt` unchanged and gives one `load_err` pulse.
- **Reset mid-run.** Drop `rst_n` between clock edges while `cnt`=0x0014 in RUN.
  - Required: `cnt`, `busy` and `tc` go to 0 without waiting for an edge.
  - After release, `start` and `adv` have no effect until a new `load`.
